// File: rtl/sdspi_pkg.sv
// Shared definitions for the SD-over-SPI card-side command channel:
// CRC7 polynomial, R1 bit positions, response type codes, FSM states.
package sdspi_pkg;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int R1_IDLE    = 0;
  localparam int R1_CRC_ERR = 3;

  localparam logic [1:0] RSP_R1   = 2'b00;
  localparam logic [1:0] RSP_R1B  = 2'b01;
  localparam logic [1:0] RSP_R3R7 = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DECODE,
    WAIT_RSP,
    SEND,
    BUSY
  } state_t;

  // R1 returned automatically when a frame fails its CRC check.
  function automatic logic [7:0] r1_crc_err(input logic in_idle);
    logic [7:0] r;
    r = 8'h00;
    r[R1_CRC_ERR] = 1'b1;
    r[R1_IDLE] = in_idle;
    return r;
  endfunction

endpackage

// File: rtl/sd_crc7_byte.sv
// Combinational SD CRC7 update: folds 8 message bits (MSB first) into crc.
// Ports: crc_in (7), data (8) -> crc_out (7).
module sd_crc7_byte
  import sdspi_pkg::*;
(
  input  logic [6:0] crc_in,
  input  logic [7:0] data,
  output logic [6:0] crc_out
);

  always_comb begin
    logic [6:0] c;
    logic fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ CRC7_POLY;
    end
    crc_out = c;
  end

endmodule

// File: rtl/spi_card_cmd.sv
// Card-side SD/SPI command channel: parses 6-byte frames, checks CRC7,
// strobes cmd/arg to the card model and returns R1/R1b/R3/R7 on MISO.
// Ports: i_clk, i_reset (sync, high), i_cs_n, LL byte link (i_ll_stb,
//  i_ll_byte, o_ll_byte), command out (o_cmd_stb, o_cmd, o_cmd_arg,
//  o_crc_err), response in (o_rsp_ready, i_rsp_stb, i_rsp_type,
//  i_rsp_data, i_busy_hold, i_in_idle).
module spi_card_cmd
  import sdspi_pkg::*;
#(
  parameter int NCR     = 1,
  parameter bit OPT_CRC = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cs_n,
  input  logic        i_ll_stb,
  input  logic [7:0]  i_ll_byte,
  output logic [7:0]  o_ll_byte,
  output logic        o_cmd_stb,
  output logic [5:0]  o_cmd,
  output logic [31:0] o_cmd_arg,
  output logic        o_crc_err,
  output logic        o_rsp_ready,
  input  logic        i_rsp_stb,
  input  logic [1:0]  i_rsp_type,
  input  logic [39:0] i_rsp_data,
  input  logic        i_busy_hold,
  input  logic        i_in_idle
);

  localparam logic [3:0] NCR_L = 4'(NCR);

  state_t      state;
  logic [5:0]  cmd_idx;
  logic [31:0] arg_sr;
  logic [6:0]  crc;
  logic [2:0]  byte_cnt;
  logic        crc_bad;
  logic [3:0]  slot_cnt;
  logic        have_rsp;
  logic [1:0]  rsp_type;
  logic [39:0] rsp_data;
  logic [2:0]  send_idx;

  logic [6:0]  crc_seed;
  logic [6:0]  crc_next;
  logic [3:0]  slot_nxt;
  logic        rsp_take;
  logic        rsp_avail;
  logic [7:0]  r1_nxt;
  logic [2:0]  last_idx;
  logic [31:0] word_sh;

  // Start byte seeds the CRC from zero; later bytes chain.
  assign crc_seed = (state == IDLE) ? 7'd0 : crc;

  sd_crc7_byte u_crc (
    .crc_in  (crc_seed),
    .data    (i_ll_byte),
    .crc_out (crc_next)
  );

  assign slot_nxt  = slot_cnt + {3'd0, (i_ll_stb && slot_cnt < 4'd8)};
  assign rsp_take  = i_rsp_stb && o_rsp_ready;
  assign rsp_avail = have_rsp || rsp_take;
  assign r1_nxt    = have_rsp ? rsp_data[39:32] : i_rsp_data[39:32];
  assign last_idx  = rsp_type[1] ? 3'd4 : 3'd0;
  assign word_sh   = rsp_data[31:0] << {send_idx[1:0], 3'b000};

  always_ff @(posedge i_clk) begin
    o_cmd_stb <= 1'b0;
    o_crc_err <= 1'b0;
    if (i_reset) begin
      state       <= IDLE;
      o_ll_byte   <= 8'hff;
      o_rsp_ready <= 1'b0;
      o_cmd       <= '0;
      o_cmd_arg   <= '0;
      cmd_idx     <= '0;
      arg_sr      <= '0;
      crc         <= '0;
      byte_cnt    <= '0;
      crc_bad     <= 1'b0;
      slot_cnt    <= '0;
      have_rsp    <= 1'b0;
      rsp_type    <= RSP_R1;
      rsp_data    <= '0;
      send_idx    <= '0;
    end else if (i_cs_n) begin
      state       <= IDLE;
      o_ll_byte   <= 8'hff;
      o_rsp_ready <= 1'b0;
      have_rsp    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          o_ll_byte <= 8'hff;
          if (i_ll_stb && i_ll_byte[7:6] == 2'b01) begin
            state    <= CMD;
            cmd_idx  <= i_ll_byte[5:0];
            crc      <= crc_next;
            byte_cnt <= '0;
          end
        end
        CMD: begin
          if (i_ll_stb) begin
            if (byte_cnt == 3'd4) begin
              state   <= DECODE;
              crc_bad <= OPT_CRC && (i_ll_byte != {crc, 1'b1});
              if (OPT_CRC && (i_ll_byte != {crc, 1'b1})) begin
                o_crc_err <= 1'b1;
              end else begin
                o_cmd_stb <= 1'b1;
                o_cmd     <= cmd_idx;
                o_cmd_arg <= arg_sr;
              end
            end else begin
              arg_sr   <= {arg_sr[23:0], i_ll_byte};
              crc      <= crc_next;
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        DECODE: begin
          state       <= WAIT_RSP;
          slot_cnt    <= '0;
          o_ll_byte   <= 8'hff;
          have_rsp    <= crc_bad;
          o_rsp_ready <= !crc_bad;
          if (crc_bad) begin
            rsp_type <= RSP_R1;
            rsp_data <= {r1_crc_err(i_in_idle), 32'h0};
          end
        end
        WAIT_RSP: begin
          slot_cnt <= slot_nxt;
          if (rsp_take) begin
            o_rsp_ready <= 1'b0;
            have_rsp    <= 1'b1;
            rsp_type    <= i_rsp_type;
            rsp_data    <= i_rsp_data;
          end
          // R1 goes out only after NCR filler slots and a response.
          if (rsp_avail && slot_nxt >= NCR_L) begin
            state     <= SEND;
            o_ll_byte <= r1_nxt;
            send_idx  <= '0;
          end else begin
            o_ll_byte <= 8'hff;
          end
        end
        SEND: begin
          if (i_ll_stb) begin
            if (send_idx == last_idx) begin
              have_rsp <= 1'b0;
              if (rsp_type == RSP_R1B) begin
                state     <= BUSY;
                o_ll_byte <= 8'h00;
              end else begin
                state     <= IDLE;
                o_ll_byte <= 8'hff;
              end
            end else begin
              o_ll_byte <= word_sh[31:24];
              send_idx  <= send_idx + 3'd1;
            end
          end
        end
        BUSY: begin
          if (i_ll_stb && !i_busy_hold) begin
            state     <= IDLE;
            o_ll_byte <= 8'hff;
          end
        end
        default: begin
          state     <= IDLE;
          o_ll_byte <= 8'hff;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_card_cmd.sv
// Directed bench for spi_card_cmd (default and CRC-ignoring instances).
// MISO bytes are sampled at the slot where the LL would latch them.
module tb_spi_card_cmd;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n;
  logic        ll_stb;
  logic [7:0]  ll_byte;
  logic        rsp_stb;
  logic [1:0]  rsp_type;
  logic [39:0] rsp_data;
  logic        busy_hold;
  logic        in_idle;

  logic [7:0]  miso, miso_nc;
  logic        cmd_stb, cmd_stb_nc;
  logic [5:0]  cmd, cmd_nc;
  logic [31:0] arg, arg_nc;
  logic        crc_err, crc_err_nc;
  logic        rdy, rdy_nc;

  int checks = 0;
  int failures = 0;
  int n_cmd = 0, n_err = 0, n_cmd_nc = 0, n_err_nc = 0;

  always #5 clk = ~clk;

  spi_card_cmd dut (
    .i_clk(clk), .i_reset(reset), .i_cs_n(cs_n),
    .i_ll_stb(ll_stb), .i_ll_byte(ll_byte), .o_ll_byte(miso),
    .o_cmd_stb(cmd_stb), .o_cmd(cmd), .o_cmd_arg(arg),
    .o_crc_err(crc_err), .o_rsp_ready(rdy),
    .i_rsp_stb(rsp_stb), .i_rsp_type(rsp_type), .i_rsp_data(rsp_data),
    .i_busy_hold(busy_hold), .i_in_idle(in_idle)
  );

  spi_card_cmd #(.NCR(1), .OPT_CRC(1'b0)) dut_nc (
    .i_clk(clk), .i_reset(reset), .i_cs_n(cs_n),
    .i_ll_stb(ll_stb), .i_ll_byte(ll_byte), .o_ll_byte(miso_nc),
    .o_cmd_stb(cmd_stb_nc), .o_cmd(cmd_nc), .o_cmd_arg(arg_nc),
    .o_crc_err(crc_err_nc), .o_rsp_ready(rdy_nc),
    .i_rsp_stb(rsp_stb), .i_rsp_type(rsp_type), .i_rsp_data(rsp_data),
    .i_busy_hold(busy_hold), .i_in_idle(in_idle)
  );

  always @(negedge clk) begin
    if (cmd_stb) n_cmd++;
    if (crc_err) n_err++;
    if (cmd_stb_nc) n_cmd_nc++;
    if (crc_err_nc) n_err_nc++;
  end

  task automatic xfer(input logic [7:0] mosi, output logic [7:0] m);
    @(negedge clk);
    ll_byte = mosi;
    ll_stb = 1'b1;
    m = miso;
    @(negedge clk);
    ll_stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [47:0] f);
    logic [7:0] m;
    for (int i = 0; i < 6; i++) xfer(f[47-8*i -: 8], m);
  endtask

  task automatic give_rsp(input logic [1:0] t, input logic [39:0] d);
    int n = 0;
    @(negedge clk);
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rdy) begin
      failures++;
      $display("FAIL rsp_ready_wait: got %b want 1", rdy);
    end
    rsp_type = t;
    rsp_data = d;
    rsp_stb = 1'b1;
    @(negedge clk);
    rsp_stb = 1'b0;
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL rsp_ready_drop: got %b want 0", rdy);
    end
  endtask

  task automatic deselect();
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cs_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (miso !== 8'hff) begin
      failures++;
      $display("FAIL reset_miso: got %h want ff", miso);
    end
    checks++;
    if ({cmd_stb, crc_err, rdy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 000", {cmd_stb, crc_err, rdy});
    end
    checks++;
    if (cmd !== 6'd0 || arg !== 32'd0) begin
      failures++;
      $display("FAIL reset_cmd: got %h/%h want 0/0", cmd, arg);
    end
  endtask

  task automatic test_cmd0();
    logic [7:0] m;
    logic [7:0] exp [3] = '{8'hff, 8'h01, 8'hff};
    int bc = n_cmd, be = n_err;
    send_frame(48'h40_00000000_95);
    checks++;
    if (n_cmd !== bc + 1 || n_err !== be) begin
      failures++;
      $display("FAIL cmd0_strobe: got stb=%0d err=%0d want 1/0",
               n_cmd - bc, n_err - be);
    end
    checks++;
    if (cmd !== 6'd0 || arg !== 32'd0) begin
      failures++;
      $display("FAIL cmd0_fields: got %0d/%h want 0/0", cmd, arg);
    end
    give_rsp(2'b00, {8'h01, 32'h0});
    for (int i = 0; i < 3; i++) begin
      xfer(8'hff, m);
      checks++;
      if (m !== exp[i]) begin
        failures++;
        $display("FAIL cmd0_miso[%0d]: got %h want %h", i, m, exp[i]);
      end
    end
  endtask

  task automatic test_cmd8();
    logic [7:0] m;
    logic [7:0] exp [7] = '{8'hff, 8'h01, 8'h00, 8'h00, 8'h01, 8'haa, 8'hff};
    int bc = n_cmd;
    send_frame(48'h48_000001AA_87);
    checks++;
    if (n_cmd !== bc + 1 || cmd !== 6'd8 || arg !== 32'h1aa) begin
      failures++;
      $display("FAIL cmd8_fields: got n=%0d cmd=%0d arg=%h want 1/8/1aa",
               n_cmd - bc, cmd, arg);
    end
    give_rsp(2'b10, {8'h01, 32'h0000_01aa});
    for (int i = 0; i < 7; i++) begin
      xfer(8'hff, m);
      checks++;
      if (m !== exp[i]) begin
        failures++;
        $display("FAIL cmd8_miso[%0d]: got %h want %h", i, m, exp[i]);
      end
    end
  endtask

  task automatic test_crc_err();
    logic [7:0] m;
    logic [7:0] exp [3] = '{8'hff, 8'h09, 8'hff};
    int bc = n_cmd, be = n_err, bcn = n_cmd_nc, ben = n_err_nc;
    in_idle = 1'b1;
    send_frame(48'h40_00000000_94);
    checks++;
    if (n_err !== be + 1 || n_cmd !== bc) begin
      failures++;
      $display("FAIL crc_err_pulse: got err=%0d stb=%0d want 1/0",
               n_err - be, n_cmd - bc);
    end
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL crc_err_ready: got %b want 0", rdy);
    end
    checks++;
    if (n_cmd_nc !== bcn + 1 || n_err_nc !== ben || cmd_nc !== 6'd0) begin
      failures++;
      $display("FAIL nocrc_accept: got stb=%0d err=%0d cmd=%0d want 1/0/0",
               n_cmd_nc - bcn, n_err_nc - ben, cmd_nc);
    end
    for (int i = 0; i < 3; i++) begin
      xfer(8'hff, m);
      checks++;
      if (m !== exp[i]) begin
        failures++;
        $display("FAIL crc_err_miso[%0d]: got %h want %h", i, m, exp[i]);
      end
    end
    in_idle = 1'b0;
    deselect();
  endtask

  task automatic test_r1b_busy();
    logic [7:0] m;
    logic [7:0] exp [6] = '{8'hff, 8'h00, 8'h00, 8'h00, 8'h00, 8'hff};
    logic       hold [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    send_frame(48'h40_00000000_95);
    give_rsp(2'b01, {8'h00, 32'h0});
    for (int i = 0; i < 6; i++) begin
      busy_hold = hold[i];
      xfer(8'hff, m);
      checks++;
      if (m !== exp[i]) begin
        failures++;
        $display("FAIL r1b_miso[%0d]: got %h want %h", i, m, exp[i]);
      end
    end
    busy_hold = 1'b0;
  endtask

  task automatic test_cs_abort();
    logic [7:0] m;
    logic [7:0] exp [3] = '{8'hff, 8'h00, 8'hff};
    int bc = n_cmd, be = n_err;
    xfer(8'h40, m);
    xfer(8'h00, m);
    xfer(8'h00, m);
    deselect();
    send_frame(48'h51_00000000_55);
    checks++;
    if (n_cmd !== bc + 1 || n_err !== be || cmd !== 6'd17) begin
      failures++;
      $display("FAIL cs_abort: got stb=%0d err=%0d cmd=%0d want 1/0/17",
               n_cmd - bc, n_err - be, cmd);
    end
    give_rsp(2'b00, {8'h00, 32'h0});
    for (int i = 0; i < 3; i++) begin
      xfer(8'hff, m);
      checks++;
      if (m !== exp[i]) begin
        failures++;
        $display("FAIL cs_abort_miso[%0d]: got %h want %h", i, m, exp[i]);
      end
    end
  endtask

  task automatic test_late_rsp();
    logic [7:0] m;
    send_frame(48'h40_00000000_95);
    for (int i = 0; i < 5; i++) begin
      xfer(8'hff, m);
      checks++;
      if (m !== 8'hff) begin
        failures++;
        $display("FAIL late_fill[%0d]: got %h want ff", i, m);
      end
    end
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL late_ready: got %b want 1", rdy);
    end
    give_rsp(2'b00, {8'h01, 32'h0});
    xfer(8'hff, m);
    checks++;
    if (m !== 8'h01) begin
      failures++;
      $display("FAIL late_r1: got %h want 01", m);
    end
    xfer(8'hff, m);
    checks++;
    if (m !== 8'hff) begin
      failures++;
      $display("FAIL late_tail: got %h want ff", m);
    end
  endtask

  task automatic test_reset_in_send();
    logic [7:0] m;
    int bc;
    send_frame(48'h48_000001AA_87);
    give_rsp(2'b10, {8'h01, 32'h0000_01aa});
    xfer(8'hff, m);
    xfer(8'hff, m);
    checks++;
    if (miso !== 8'h00) begin
      failures++;
      $display("FAIL send_mid: got %h want 00", miso);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (miso !== 8'hff || rdy !== 1'b0) begin
      failures++;
      $display("FAIL send_reset: got %h/%b want ff/0", miso, rdy);
    end
    bc = n_cmd;
    send_frame(48'h40_00000000_95);
    checks++;
    if (n_cmd !== bc + 1) begin
      failures++;
      $display("FAIL post_reset_frame: got %0d want 1", n_cmd - bc);
    end
    give_rsp(2'b00, {8'h01, 32'h0});
    xfer(8'hff, m);
    xfer(8'hff, m);
    checks++;
    if (m !== 8'h01) begin
      failures++;
      $display("FAIL post_reset_r1: got %h want 01", m);
    end
    xfer(8'hff, m);
  endtask

  initial begin
    reset = 1'b1;
    cs_n = 1'b0;
    ll_stb = 1'b0;
    ll_byte = 8'hff;
    rsp_stb = 1'b0;
    rsp_type = 2'b00;
    rsp_data = '0;
    busy_hold = 1'b0;
    in_idle = 1'b0;
    test_reset();
    test_cmd0();
    test_cmd8();
    test_crc_err();
    test_r1b_busy();
    test_cs_abort();
    test_late_rsp();
    test_reset_in_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
